// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and its baud-tick counter.
//   CLKS_PER_BIT_DEF : default clk_3125 cycles per bit (3.125 MHz / 14 ~= 223 kbaud)
//   STOP_BITS_DEF    : default stop bits per frame
//   uart_state_e     : 3-bit frame state, numbered the same as the receiver
//   frame_clks()     : cycles per frame = (start + 8 data + parity + stop) bits
//   cnt_width()      : width of the per-bit cycle counter
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 14;
  localparam int STOP_BITS_DEF    = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic int frame_clks(input int clks_per_bit, input int stop_bits);
    return (10 + stop_bits) * clks_per_bit;
  endfunction

  // The counter has to reach the end of the (possibly multi-bit) stop
  // period, so it is sized for STOP_BITS*CLKS_PER_BIT.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int FRAME_CLKS = frame_clks(CLKS_PER_BIT_DEF, STOP_BITS_DEF);

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit cycle counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps at every bit boundary; while long_bit is
// high (stop period) it runs to STOP_BITS*CLKS_PER_BIT-1 instead, so multiple
// stop bits read as one long bit.
// Ports:
//   clk      in  sole clock
//   rst      in  synchronous active-high reset (counter -> 0)
//   clear    in  synchronous clear; holds the counter at 0 while the line is idle
//   long_bit in  select the stop-period length for the current bit
//   tick     out high in the final cycle of the current bit
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = STOP_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic long_bit,
  output logic tick
);

  localparam int            CW        = cnt_width(STOP_BITS * CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS * CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == (long_bit ? LAST_STOP : LAST_BIT));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with a one-entry holding register.
// Frame: start(0), 8 data bits MSB first, even parity (^data), STOP_BITS stop(1).
// A byte queued while a frame is on the line goes out immediately after the
// last stop bit with no idle gap.
// Ports:
//   clk_3125   in   sole clock, posedge
//   rst        in   synchronous active-high reset
//   tx_start   in   host offers tx_data; accepted iff tx_ready
//   tx_data    in   payload byte, sampled on acceptance only
//   tx_ready   out  holding register empty
//   tx         out  registered serial line, idle high
//   tx_busy    out  frame on the line (start .. last stop bit)
//   tx_done    out  pulse in the final cycle of the last stop bit
//   tx_overrun out  pulse when tx_start arrives while the holding register is full
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = STOP_BITS_DEF
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun
);

  uart_state_e state, next_state;

  logic [7:0] hold_byte;
  logic       hold_valid;
  logic [7:0] shift_byte;
  logic       parity_bit;
  logic [2:0] bit_idx, bit_idx_next;
  logic       tx_next;
  logic       tick;
  logic       launch;   // move holding reg into the shifter, start a frame
  logic       accept;   // latch tx_data into the holding reg

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_baud (
    .clk      (clk_3125),
    .rst      (rst),
    .clear    (state == IDLE),
    .long_bit (state == STOP),
    .tick     (tick)
  );

  // State register and datapath registers.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= 3'd0;
      tx         <= 1'b1;
      hold_valid <= 1'b0;
      hold_byte  <= 8'h00;
      shift_byte <= 8'h00;
      parity_bit <= 1'b0;
    end else begin
      state   <= next_state;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      if (launch) begin
        shift_byte <= hold_byte;
        parity_bit <= ^hold_byte;   // parity frozen with the byte it covers
      end
      if (accept)      begin hold_byte <= tx_data; hold_valid <= 1'b1; end
      else if (launch) hold_valid <= 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state   = state;
    bit_idx_next = bit_idx;
    launch       = 1'b0;
    case (state)
      IDLE: if (hold_valid) begin
        next_state = START;
        launch     = 1'b1;
      end
      START: if (tick) begin
        next_state   = DATA;
        bit_idx_next = 3'd7;
      end
      DATA: if (tick) begin
        if (bit_idx == 3'd0) next_state = PARITY;
        else                 bit_idx_next = bit_idx - 3'd1;
      end
      PARITY: if (tick) next_state = STOP;
      STOP: if (tick) begin
        // Queued byte loads in the last stop cycle: next start bit follows directly.
        if (hold_valid) begin
          next_state = START;
          launch     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs. tx is computed from the upcoming state so the registered line
  // changes exactly at the bit boundary.
  always_comb begin
    tx_ready   = !hold_valid;
    accept     = tx_start && !hold_valid;
    tx_overrun = tx_start && hold_valid;
    tx_busy    = (state != IDLE);
    tx_done    = (state == STOP) && tick;
    case (next_state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_byte[bit_idx_next];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
  end

endmodule
